// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_pkg
//  Description : Shared constants and types for the writeback arbiter:
//                source count, per-source index map, field widths and the
//                holding-slot record.
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam int N_SRC  = 16;
    localparam int RT_W   = 5;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 5;
    localparam int PTR_W  = $clog2(N_SRC);

    // Source index map: ALU lanes first, then upper/lower pairs per FPU unit
    localparam int SRC_ALU_U   = 0;
    localparam int SRC_ALU_L   = 1;
    localparam int SRC_FADD_U  = 2;
    localparam int SRC_FADD_L  = 3;
    localparam int SRC_FSUB_U  = 4;
    localparam int SRC_FSUB_L  = 5;
    localparam int SRC_FMUL_U  = 6;
    localparam int SRC_FMUL_L  = 7;
    localparam int SRC_FDIV_U  = 8;
    localparam int SRC_FDIV_L  = 9;
    localparam int SRC_FSQRT_U = 10;
    localparam int SRC_FSQRT_L = 11;
    localparam int SRC_FTOI_U  = 12;
    localparam int SRC_FTOI_L  = 13;
    localparam int SRC_ITOF_U  = 14;
    localparam int SRC_ITOF_L  = 15;

    typedef struct packed {
        logic              valid;
        logic [RT_W-1:0]   rt;
        logic [DATA_W-1:0] data;
    } wb_slot_t;

endpackage
`default_nettype wire

// File: rtl/wb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter_if
//  Description : Result-source and register-file-write bundle of the
//                writeback arbiter.
//                master : result producers / register file side
//                slave  : the arbiter
//                src_valid/src_rt/src_data : per-source result triples
//                wr0_*/wr1_*               : two register-file write ports
//                stall_req, pending_cnt, err_overflow : status
//  Revision    : 1.0 - initial release
// ============================================================================
interface wb_arbiter_if;
    import wb_pkg::*;

    logic [N_SRC-1:0]        src_valid;
    logic [N_SRC*RT_W-1:0]   src_rt;
    logic [N_SRC*DATA_W-1:0] src_data;

    logic                    wr0_en;
    logic [RT_W-1:0]         wr0_addr;
    logic [DATA_W-1:0]       wr0_data;
    logic                    wr1_en;
    logic [RT_W-1:0]         wr1_addr;
    logic [DATA_W-1:0]       wr1_data;

    logic                    stall_req;
    logic [CNT_W-1:0]        pending_cnt;
    logic                    err_overflow;

    modport master (
        output src_valid, src_rt, src_data,
        input  wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
        input  stall_req, pending_cnt, err_overflow
    );

    modport slave (
        input  src_valid, src_rt, src_data,
        output wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
        output stall_req, pending_cnt, err_overflow
    );

endinterface
`default_nettype wire

// File: rtl/rr_find_first.sv
`default_nettype none
// ============================================================================
//  Module      : rr_find_first
//  Description : Combinational circular find-first-set. Searches i_mask
//                upward from i_start, wrapping modulo N.
//                i_mask  : candidate bits
//                i_start : first index examined
//                o_found : any bit set
//                o_idx   : index of the first set bit in circular order
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_find_first #(
    parameter int N = 16,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] i_mask,
    input  logic [W-1:0] i_start,
    output logic         o_found,
    output logic [W-1:0] o_idx
);

    logic [W-1:0] w_cand [N];

    function automatic logic [W-1:0] wrap_add(input logic [W-1:0] a, input int k);
        int s;
        s = int'(a) + k;
        if (s >= N) s = s - N;
        return W'(s);
    endfunction

    // w_cand[k] is the k-th index visited starting from i_start
    for (genvar k = 0; k < N; k++) begin : g_cand
        assign w_cand[k] = wrap_add(i_start, k);
    end

    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (!o_found && i_mask[w_cand[k]]) begin
                o_found = 1'b1;
                o_idx   = w_cand[k];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter
//  Description : Writeback collector. Each result source owns one holding
//                slot; a round-robin scheduler retires up to two slots per
//                cycle onto the register-file write ports, never writing the
//                same register twice in one cycle.
//                clk  : clock
//                rstn : synchronous active-low reset
//                wb   : source triples in, write ports and status out
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int STALL_TH = 2
) (
    input  logic        clk,
    input  logic        rstn,
    wb_arbiter_if.slave wb
);

    wb_slot_t          r_slot     [N_SRC];
    wb_slot_t          w_slot_nxt [N_SRC];
    logic [PTR_W-1:0]  r_ptr;
    logic [PTR_W-1:0]  w_ptr_nxt;

    logic [N_SRC-1:0]  w_valid;
    logic [N_SRC-1:0]  w_mask1;
    logic [N_SRC-1:0]  w_granted;
    logic              w_g0_found;
    logic              w_g1_found;
    logic [PTR_W-1:0]  w_g0;
    logic [PTR_W-1:0]  w_g1;
    logic [RT_W-1:0]   w_g0_rt;
    logic              w_overflow;
    logic [CNT_W-1:0]  w_nxt_cnt;

    logic              r_wr0_en;
    logic [RT_W-1:0]   r_wr0_addr;
    logic [DATA_W-1:0] r_wr0_data;
    logic              r_wr1_en;
    logic [RT_W-1:0]   r_wr1_addr;
    logic [DATA_W-1:0] r_wr1_data;
    logic              r_stall;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err;

    function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] idx);
        return (idx == PTR_W'(N_SRC - 1)) ? '0 : idx + 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < N_SRC; i++) w_valid[i] = r_slot[i].valid;
    end

    rr_find_first #(.N(N_SRC), .W(PTR_W)) u_find_g0 (
        .i_mask  (w_valid),
        .i_start (r_ptr),
        .o_found (w_g0_found),
        .o_idx   (w_g0)
    );

    assign w_g0_rt = r_slot[w_g0].rt;

    // Second grant skips g0 itself and anything targeting g0's register,
    // so the two write ports never hit the same register in one cycle.
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            w_mask1[i] = r_slot[i].valid && (w_g0 != PTR_W'(i)) && (r_slot[i].rt != w_g0_rt);
        end
    end

    // Starting at g0 is equivalent to starting just after it: g0 is masked.
    rr_find_first #(.N(N_SRC), .W(PTR_W)) u_find_g1 (
        .i_mask  (w_mask1),
        .i_start (w_g0),
        .o_found (w_g1_found),
        .o_idx   (w_g1)
    );

    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            w_granted[i] = (w_g0_found && (w_g0 == PTR_W'(i))) ||
                           (w_g1_found && (w_g1 == PTR_W'(i)));
        end
    end

    // A granted slot frees at this edge, so a same-edge arrival reloads it;
    // an arrival into a slot that stays occupied is dropped.
    always_comb begin
        w_overflow = 1'b0;
        w_nxt_cnt  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            w_slot_nxt[i] = r_slot[i];
            if (w_granted[i]) w_slot_nxt[i].valid = 1'b0;
            if (wb.src_valid[i]) begin
                if (r_slot[i].valid && !w_granted[i]) begin
                    w_overflow = 1'b1;
                end else begin
                    w_slot_nxt[i].valid = 1'b1;
                    w_slot_nxt[i].rt    = wb.src_rt[i*RT_W +: RT_W];
                    w_slot_nxt[i].data  = wb.src_data[i*DATA_W +: DATA_W];
                end
            end
            w_nxt_cnt = w_nxt_cnt + CNT_W'(w_slot_nxt[i].valid);
        end
    end

    always_comb begin
        w_ptr_nxt = r_ptr;
        if (w_g1_found)      w_ptr_nxt = next_idx(w_g1);
        else if (w_g0_found) w_ptr_nxt = next_idx(w_g0);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < N_SRC; i++) r_slot[i] <= '0;
            r_ptr      <= '0;
            r_wr0_en   <= 1'b0;
            r_wr0_addr <= '0;
            r_wr0_data <= '0;
            r_wr1_en   <= 1'b0;
            r_wr1_addr <= '0;
            r_wr1_data <= '0;
            r_stall    <= 1'b0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
        end else begin
            for (int i = 0; i < N_SRC; i++) r_slot[i] <= w_slot_nxt[i];
            r_ptr    <= w_ptr_nxt;
            r_wr0_en <= w_g0_found;
            if (w_g0_found) begin
                r_wr0_addr <= r_slot[w_g0].rt;
                r_wr0_data <= r_slot[w_g0].data;
            end
            r_wr1_en <= w_g1_found;
            if (w_g1_found) begin
                r_wr1_addr <= r_slot[w_g1].rt;
                r_wr1_data <= r_slot[w_g1].data;
            end
            r_stall <= (w_nxt_cnt > CNT_W'(STALL_TH));
            r_cnt   <= w_nxt_cnt;
            if (w_overflow) r_err <= 1'b1;
        end
    end

    assign wb.wr0_en       = r_wr0_en;
    assign wb.wr0_addr     = r_wr0_addr;
    assign wb.wr0_data     = r_wr0_data;
    assign wb.wr1_en       = r_wr1_en;
    assign wb.wr1_addr     = r_wr1_addr;
    assign wb.wr1_data     = r_wr1_data;
    assign wb.stall_req    = r_stall;
    assign wb.pending_cnt  = r_cnt;
    assign wb.err_overflow = r_err;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_arbiter
//  Description : Self-checking bench for wb_arbiter: a per-cycle vector
//                table for grant/ordering cases and a write scoreboard for
//                streaming, overflow and reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;
    import wb_pkg::*;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    wb_arbiter_if bus ();

    wb_arbiter #(.STALL_TH(2)) dut (
        .clk  (clk),
        .rstn (rstn),
        .wb   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [4:0]  rt;
        logic [31:0] data;
    } wr_t;
    wr_t sb_q[$];

    // Up to three sources driven per row; outputs expected after that cycle's edge
    typedef struct {
        int          ia, ib, ic;
        logic [4:0]  ra, rb, rc;
        logic [31:0] da, db, dc;
        logic        e0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        e1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        stall;
        logic [4:0]  pend;
    } vec_t;

    localparam int NV = 15;
    vec_t vt [NV];

    function automatic vec_t mk(
        input int ia, input logic [4:0] ra, input logic [31:0] da,
        input int ib, input logic [4:0] rb, input logic [31:0] db,
        input int ic, input logic [4:0] rc, input logic [31:0] dc,
        input logic e0, input logic [4:0] a0, input logic [31:0] d0,
        input logic e1, input logic [4:0] a1, input logic [31:0] d1,
        input logic stall, input logic [4:0] pend);
        vec_t v;
        v.ia = ia; v.ra = ra; v.da = da;
        v.ib = ib; v.rb = rb; v.db = db;
        v.ic = ic; v.rc = rc; v.dc = dc;
        v.e0 = e0; v.a0 = a0; v.d0 = d0;
        v.e1 = e1; v.a1 = a1; v.d1 = d1;
        v.stall = stall; v.pend = pend;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic clr_src;
        bus.src_valid = '0;
        bus.src_rt    = '0;
        bus.src_data  = '0;
    endtask

    task automatic set_src(input int idx, input logic [4:0] rt, input logic [31:0] d);
        if (idx < 0) return;
        bus.src_valid[idx]      = 1'b1;
        bus.src_rt[idx*5 +: 5]  = rt;
        bus.src_data[idx*32 +: 32] = d;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sb_pop(input string name, input logic [4:0] addr, input logic [31:0] data);
        wr_t e;
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_unexpected: actual addr=%0d data=0x%0h, required no write", name, addr, data);
        end else begin
            e = sb_q.pop_front();
            chk({name, "_addr"}, 32'(addr), 32'(e.rt));
            chk({name, "_data"}, data, e.data);
        end
    endtask

    task automatic sb_monitor;
        if (bus.wr0_en) sb_pop("sb_wr0", bus.wr0_addr, bus.wr0_data);
        if (bus.wr1_en) sb_pop("sb_wr1", bus.wr1_addr, bus.wr1_data);
    endtask

    task automatic sb_drain(input string name);
        for (int c = 0; c < 8; c++) begin
            if (sb_q.size() == 0) break;
            tick;
            sb_monitor;
        end
        chk({name, "_left"}, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_wr0_en"},   32'(bus.wr0_en), 32'd0);
        chk({name, "_wr0_addr"}, 32'(bus.wr0_addr), 32'd0);
        chk({name, "_wr0_data"}, bus.wr0_data, 32'd0);
        chk({name, "_wr1_en"},   32'(bus.wr1_en), 32'd0);
        chk({name, "_wr1_addr"}, 32'(bus.wr1_addr), 32'd0);
        chk({name, "_wr1_data"}, bus.wr1_data, 32'd0);
        chk({name, "_stall"},    32'(bus.stall_req), 32'd0);
        chk({name, "_pend"},     32'(bus.pending_cnt), 32'd0);
        chk({name, "_err"},      32'(bus.err_overflow), 32'd0);
    endtask

    initial begin
        logic [4:0]  last_a0, last_a1;
        logic [31:0] last_d0, last_d1;

        // ptr traced: 0 ->(r2) 6 ->(r4) 1 ->(r6) 0 ->(r9) 2 ->(r11) 2 ->(r14) 5
        vt[0]  = mk(0, 5'd1, 32'h11,       1, 5'd2, 32'h22, 5, 5'd7, 32'h77, 0, 0, 0,           0, 0, 0,       1, 5'd3);
        vt[1]  = mk(-1, 0, 0,              -1, 0, 0,        -1, 0, 0,        1, 5'd1, 32'h11,     1, 5'd2, 32'h22, 0, 5'd1);
        vt[2]  = mk(-1, 0, 0,              -1, 0, 0,        -1, 0, 0,        1, 5'd7, 32'h77,     0, 0, 0,       0, 5'd0);
        vt[3]  = mk(0, 5'd3, 32'h12345678, -1, 0, 0,        -1, 0, 0,        0, 0, 0,           0, 0, 0,       0, 5'd1);
        vt[4]  = mk(-1, 0, 0,              -1, 0, 0,        -1, 0, 0,        1, 5'd3, 32'h12345678, 0, 0, 0,     0, 5'd0);
        vt[5]  = mk(15, 5'd9, 32'hF0,      -1, 0, 0,        -1, 0, 0,        0, 0, 0,           0, 0, 0,       0, 5'd1);
        vt[6]  = mk(-1, 0, 0,              -1, 0, 0,        -1, 0, 0,        1, 5'd9, 32'hF0,     0, 0, 0,       0, 5'd0);
        vt[7]  = mk(0, 5'd4, 32'hA,        1, 5'd4, 32'hB,  -1, 0, 0,        0, 0, 0,           0, 0, 0,       0, 5'd2);
        vt[8]  = mk(-1, 0, 0,              -1, 0, 0,        -1, 0, 0,        1, 5'd4, 32'hA,      0, 0, 0,       0, 5'd1);
        vt[9]  = mk(-1, 0, 0,              -1, 0, 0,        -1, 0, 0,        1, 5'd4, 32'hB,      0, 0, 0,       0, 5'd0);
        vt[10] = mk(1, 5'd5, 32'h51,       3, 5'd6, 32'h63, -1, 0, 0,        0, 0, 0,           0, 0, 0,       0, 5'd2);
        vt[11] = mk(-1, 0, 0,              -1, 0, 0,        -1, 0, 0,        1, 5'd6, 32'h63,     1, 5'd5, 32'h51, 0, 5'd0);
        vt[12] = mk(2, 5'd8, 32'h1,        4, 5'd8, 32'h2,  6, 5'd10, 32'h3, 0, 0, 0,           0, 0, 0,       1, 5'd3);
        vt[13] = mk(-1, 0, 0,              -1, 0, 0,        -1, 0, 0,        1, 5'd8, 32'h1,      1, 5'd10, 32'h3, 0, 5'd1);
        vt[14] = mk(-1, 0, 0,              -1, 0, 0,        -1, 0, 0,        1, 5'd8, 32'h2,      0, 0, 0,       0, 5'd0);

        clr_src;
        rstn = 1'b0;
        tick;
        tick;
        chk_all_zero("reset");
        rstn = 1'b1;

        last_a0 = '0; last_d0 = '0; last_a1 = '0; last_d1 = '0;
        for (int r = 0; r < NV; r++) begin
            clr_src;
            set_src(vt[r].ia, vt[r].ra, vt[r].da);
            set_src(vt[r].ib, vt[r].rb, vt[r].db);
            set_src(vt[r].ic, vt[r].rc, vt[r].dc);
            tick;
            if (vt[r].e0) begin last_a0 = vt[r].a0; last_d0 = vt[r].d0; end
            if (vt[r].e1) begin last_a1 = vt[r].a1; last_d1 = vt[r].d1; end
            chk($sformatf("vec%0d_wr0_en", r),   32'(bus.wr0_en), 32'(vt[r].e0));
            chk($sformatf("vec%0d_wr0_addr", r), 32'(bus.wr0_addr), 32'(last_a0));
            chk($sformatf("vec%0d_wr0_data", r), bus.wr0_data, last_d0);
            chk($sformatf("vec%0d_wr1_en", r),   32'(bus.wr1_en), 32'(vt[r].e1));
            chk($sformatf("vec%0d_wr1_addr", r), 32'(bus.wr1_addr), 32'(last_a1));
            chk($sformatf("vec%0d_wr1_data", r), bus.wr1_data, last_d1);
            chk($sformatf("vec%0d_stall", r),    32'(bus.stall_req), 32'(vt[r].stall));
            chk($sformatf("vec%0d_pend", r),     32'(bus.pending_cnt), 32'(vt[r].pend));
        end
        chk("vec_err", 32'(bus.err_overflow), 32'd0);

        // Streaming: one result per cycle from source 0, in-order, no gaps
        for (int k = 1; k <= 20; k++) begin
            clr_src;
            set_src(0, 5'd3, 32'(k));
            sb_q.push_back('{rt: 5'd3, data: 32'(k)});
            tick;
            sb_monitor;
            if (k >= 2) chk($sformatf("stream_en_%0d", k), 32'(bus.wr0_en), 32'd1);
        end
        clr_src;
        sb_drain("stream");
        chk("stream_err", 32'(bus.err_overflow), 32'd0);

        // Bring ptr back to 0 by granting source 15 alone
        clr_src;
        set_src(15, 5'd9, 32'hF0);
        sb_q.push_back('{rt: 5'd9, data: 32'hF0});
        tick;
        sb_monitor;
        clr_src;
        tick;
        sb_monitor;

        // Overflow: slots 0..5 filled, then source 5 again while still pending
        for (int i = 0; i < 6; i++) begin
            set_src(i, 5'(10 + i), 32'h100 + 32'(i));
            sb_q.push_back('{rt: 5'(10 + i), data: 32'h100 + 32'(i)});
        end
        tick;
        sb_monitor;
        chk("ovf_pre_err", 32'(bus.err_overflow), 32'd0);
        clr_src;
        set_src(5, 5'd15, 32'hDEAD);
        tick;
        sb_monitor;
        chk("ovf_err", 32'(bus.err_overflow), 32'd1);
        chk("ovf_pend", 32'(bus.pending_cnt), 32'd4);
        chk("ovf_stall", 32'(bus.stall_req), 32'd1);
        clr_src;
        sb_drain("ovf");
        chk("ovf_err_sticky", 32'(bus.err_overflow), 32'd1);

        // Reset mid-operation: pending slots discarded, no stale writes later
        clr_src;
        for (int i = 2; i < 6; i++) set_src(i, 5'(20 + i), 32'hBEEF0000 + 32'(i));
        tick;
        sb_monitor;
        chk("rst_pre_pend", 32'(bus.pending_cnt), 32'd4);
        clr_src;
        rstn = 1'b0;
        tick;
        rstn = 1'b1;
        chk_all_zero("rst_mid");
        for (int c = 0; c < 6; c++) begin
            tick;
            sb_monitor;
            chk($sformatf("rst_post_pend_%0d", c), 32'(bus.pending_cnt), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
